// File: rtl/logic_result_stage.sv
// logic_result_stage: 2-entry result FIFO storing precomputed zero/ones/parity flags
module logic_result_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_res,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par,
  output logic [1:0]       level,
  output logic [7:0]       stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [1:0]       op;
    logic             zero;
    logic             ones;
    logic             par;
  } entry_t;
  state_t state, nstate;
  entry_t mem [2];
  entry_t head;
  logic wptr, rptr, push, pop;
  always_comb begin
    in_ready  = state != FULL;
    out_valid = state != EMPTY;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    nstate    = (push && !pop) ? (state == EMPTY ? ONE : FULL) :
                (pop && !push) ? (state == FULL ? ONE : EMPTY) : state;
    head      = out_valid ? mem[rptr] : '0;
    level     = state;
  end
  assign {out_res, out_op, out_zero, out_ones, out_par} = head;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      state <= nstate;
      if (push) begin
        mem[wptr] <= '{res: in_res, op: in_op, zero: in_res == '0, ones: &in_res, par: ^in_res};
        wptr      <= !wptr;
      end
      if (pop) rptr <= !rptr;
      if (in_valid && !in_ready && stall_cnt != 8'hff) stall_cnt <= stall_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_logic_result_stage.sv
// tb_logic_result_stage: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_logic_result_stage;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_res, out_res;
  logic [1:0] in_op, out_op, level;
  logic       out_zero, out_ones, out_par;
  logic [7:0] stall_cnt;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] res;
    logic [1:0] op;
  } exp_t;
  exp_t q[$];
  exp_t e;

  logic_result_stage #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_op(out_op), .out_zero(out_zero), .out_ones(out_ones),
    .out_par(out_par), .level(level), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] d,
                       input logic [1:0] o, input logic rdy);
    rst = r; in_valid = v; in_res = d; in_op = o; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // pops are compared before the same-cycle push is queued, matching FIFO order
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_pop: out_valid=1 res=%0d with no expected entry", out_res);
        end else begin
          e = q.pop_front();
          chk("pop_res", int'(out_res), int'(e.res));
          chk("pop_op", int'(out_op), int'(e.op));
          chk("pop_zero", int'(out_zero), int'(e.res == 4'd0));
          chk("pop_ones", int'(out_ones), int'(e.res == 4'hf));
          chk("pop_par", int'(out_par), int'(^e.res));
        end
      end
      if (in_valid && in_ready) q.push_back('{in_res, in_op});
    end
  end

  initial begin
    drive(1, 0, 4'd0, 2'd0, 0);
    drive(1, 0, 4'd0, 2'd0, 0);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_res", out_res, 0);
    chk("rst_flags", {out_op, out_zero, out_ones, out_par}, 0);
    chk("rst_stall", stall_cnt, 0);

    // single push, popped next cycle
    drive(0, 1, 4'b1010, 2'b00, 1);
    chk("single_valid", out_valid, 1);
    chk("single_level", level, 1);
    chk("single_res", out_res, 4'b1010);
    drive(0, 0, 4'd0, 2'd0, 1);
    chk("single_drained", level, 0);
    chk("empty_res_zero", out_res, 0);

    // fill and hold under backpressure
    drive(0, 1, 4'b0000, 2'b01, 0);
    drive(0, 1, 4'b1111, 2'b10, 0);
    chk("fill_level", level, 2);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_head_res", out_res, 0);
    chk("fill_head_zero", out_zero, 1);
    repeat (3) drive(0, 1, 4'b0101, 2'b11, 0);
    chk("hold_stall", stall_cnt, 3);
    chk("hold_res", out_res, 0);
    chk("hold_op", out_op, 2'b01);
    chk("hold_level", level, 2);
    drive(0, 0, 4'd0, 2'd0, 1);
    drive(0, 0, 4'd0, 2'd0, 1);
    chk("fill_drained", level, 0);

    // simultaneous push and pop at level 1
    drive(0, 1, 4'b0111, 2'b00, 0);
    chk("sim_head", out_res, 4'b0111);
    drive(0, 1, 4'b1000, 2'b01, 1);
    chk("sim_level", level, 1);
    chk("sim_res", out_res, 4'b1000);
    chk("sim_par", out_par, 1);
    drive(0, 0, 4'd0, 2'd0, 1);

    // full with pop: slot reusable only next cycle
    drive(0, 1, 4'b0001, 2'b00, 0);
    drive(0, 1, 4'b0010, 2'b01, 0);
    drive(0, 1, 4'b0011, 2'b10, 1);
    chk("fullpop_level", level, 1);
    chk("fullpop_in_ready", in_ready, 1);
    chk("fullpop_head", out_res, 4'b0010);
    chk("fullpop_stall", stall_cnt, 4);
    drive(0, 1, 4'b0011, 2'b10, 0);
    chk("fullpop_refill", level, 2);
    drive(0, 0, 4'd0, 2'd0, 1);
    drive(0, 0, 4'd0, 2'd0, 1);

    // stall counter saturation
    drive(0, 1, 4'b0100, 2'b00, 0);
    drive(0, 1, 4'b0110, 2'b01, 0);
    repeat (250) drive(0, 1, 4'b1001, 2'b10, 0);
    chk("stall_254", stall_cnt, 254);
    repeat (50) drive(0, 1, 4'b1001, 2'b10, 0);
    chk("stall_sat", stall_cnt, 255);
    chk("sat_head", out_res, 4'b0100);

    // reset mid-stream with push/pop attempts on the reset edge
    drive(1, 1, 4'b1011, 2'b11, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_res", out_res, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    drive(0, 0, 4'd0, 2'd0, 1);
    chk("no_stale", out_valid, 0);
    drive(0, 1, 4'b1110, 2'b11, 1);
    chk("post_rst_res", out_res, 4'b1110);
    drive(0, 0, 4'd0, 2'd0, 1);
    chk("post_rst_level", level, 0);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_result_stage.md
LOGIC_RESULT_STAGE -- requirements
Module: logic_result_stage

Interface
REQ-001 Parameter: WIDTH, default 4, result width in bits; fixed at 4 for this release, other values not required.
REQ-002 The block SHALL have one clock, clk, with all state on its rising edge; reset rst is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  upstream logic unit presents a result.
REQ-006 Port: in_ready  output  1  stage can accept a result this cycle.
REQ-007 Port: in_res  input  WIDTH  result from the logic unit (AND/OR/XOR/NOT output).
REQ-008 Port: in_op  input  2  source tag: 00 AND, 01 OR, 10 XOR, 11 NOT.
REQ-009 Port: out_valid  output  1  head entry valid.
REQ-010 Port: out_ready  input  1  downstream accepts head entry.
REQ-011 Port: out_res  output  WIDTH  head result.
REQ-012 Port: out_op  output  2  head source tag.
REQ-013 Port: out_zero  output  1  head result == 0.
REQ-014 Port: out_ones  output  1  head result all ones.
REQ-015 Port: out_par  output  1  XOR-reduction (odd parity) of head result.
REQ-016 Port: level  output  2  stored entries, 0..2.
REQ-017 Port: stall_cnt  output  8  saturating count of backpressure cycles.

Function
REQ-018 Storage SHALL be a 2-entry FIFO; each entry holds res, op, zero, ones, par.
REQ-019 Flags SHALL be computed from in_res at push time and stored with the entry.
REQ-020 in_ready SHALL be 1 exactly when level < 2, derived from registered state only (no combinational path from out_ready).
REQ-021 Push SHALL occur on in_valid && in_ready; pop on out_valid && out_ready.
REQ-022 out_valid SHALL equal (level != 0); a pushed entry is visible on outputs the cycle after acceptance (latency 1), never same-cycle.
REQ-023 Push and pop in the same cycle SHALL leave level unchanged and keep order; pushed entry lands behind the remaining one, or becomes head if level was 1.
REQ-024 When level == 2, in_ready = 0 regardless of out_ready; a pop that cycle frees one slot usable next cycle.
REQ-025 Pop when level == 0 is impossible (out_valid = 0); push when level == 2 is not accepted and input is ignored.
REQ-026 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-027 When level == 0, out_res, out_op, out_zero, out_ones, out_par SHALL be 0.
REQ-028 FIFO order SHALL be strict first-in first-out; read/write pointers wrap modulo 2.
REQ-029 stall_cnt SHALL increment by 1 each cycle with in_valid && !in_ready and saturate at 255.
REQ-030 State machine on level: EMPTY(0) -push-> ONE(1); ONE -push-only-> FULL(2); ONE -pop-only-> EMPTY; ONE -push&pop-> ONE; FULL -pop-> ONE; all other cases hold.

Reset
REQ-031 While rst = 1 at a clock edge, level, pointers, stall_cnt SHALL clear to 0; out_valid = 0, in_ready = 1 the following cycle.
REQ-032 Reset mid-operation SHALL discard stored entries; no stale entry may appear after reset, and push/pop attempts on the reset edge are ignored.
REQ-033 All outputs SHALL be 0 after reset except in_ready = 1.

Verification
REQ-034 Single push: in_res=4'b1010, in_op=00, out_ready=1 -> next cycle out_valid=1, out_res=1010, out_op=00, zero=0, ones=0, par=0; popped, level back to 0.
REQ-035 Fill: two pushes (0000 op 01, 1111 op 10), out_ready=0 -> level=2, in_ready=0, head 0000 with zero=1; hold 3 cycles with in_valid=1 -> stall_cnt=3, outputs stable.
REQ-036 Simultaneous: level=1 (head 0111), push 1000 while popping -> level stays 1, next head 1000, par=1.
REQ-037 Full with pop: level=2, out_ready=1, in_valid=1 -> that cycle no push (in_ready=0), level=1; next cycle push accepted, level=2; order preserved.
REQ-038 Saturation: in_valid=1, level=2, out_ready=0 for 300 cycles -> stall_cnt=255.
REQ-039 Reset mid-stream: level=2, assert rst one cycle -> level=0, out_valid=0, out_res=0, stall_cnt=0, in_ready=1.
